// File: rtl/fifo_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_gen_pkg
// Description : Shared sizing helpers and default geometry for the generic
//               synchronous FIFO (sync_fifo_gen) and its storage array.
//               cnt_w(depth) : width able to hold 0..depth inclusive
//               ptr_w(depth) : width able to address depth entries (min 1)
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_gen_pkg;

    localparam int c_DEFAULT_WIDTH = 16;
    localparam int c_DEFAULT_DEPTH = 8;

    // Occupancy runs 0..depth, so depth+1 distinct values are needed.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointers address 0..depth-1; never let the width collapse to zero.
    function automatic int ptr_w(input int depth);
        return ($clog2(depth) < 1) ? 1 : $clog2(depth);
    endfunction

endpackage : fifo_gen_pkg
`default_nettype wire

// File: rtl/fifo_gen_mem.sv
`default_nettype none
// ============================================================================
// Module      : fifo_gen_mem
// Description : FIFO_DEPTH x FIFO_WIDTH register array used as FIFO storage.
//               One synchronous write port, one asynchronous read port.
//               Contents are deliberately not reset.
// Ports       : clk        - clock, rising edge
//               i_wr_en    - write strobe
//               i_wr_addr  - write address (0..FIFO_DEPTH-1)
//               i_wr_data  - write data
//               i_rd_addr  - read address (0..FIFO_DEPTH-1)
//               o_rd_data  - read data, combinational from i_rd_addr
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_gen_mem
    import fifo_gen_pkg::*;
#(
    parameter int FIFO_WIDTH = c_DEFAULT_WIDTH,
    parameter int FIFO_DEPTH = c_DEFAULT_DEPTH
) (
    input  logic                             clk,
    input  logic                             i_wr_en,
    input  logic [ptr_w(FIFO_DEPTH)-1:0]     i_wr_addr,
    input  logic [FIFO_WIDTH-1:0]            i_wr_data,
    input  logic [ptr_w(FIFO_DEPTH)-1:0]     i_rd_addr,
    output logic [FIFO_WIDTH-1:0]            o_rd_data
);

    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Addresses are kept below FIFO_DEPTH by the pointer wrap logic in the
    // parent, so no range guard is needed for non-power-of-two depths.
    assign o_rd_data = r_mem[i_rd_addr];

endmodule : fifo_gen_mem
`default_nettype wire

// File: rtl/sync_fifo_gen.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_gen
// Description : Generic single-clock FIFO. Any depth >= 2, programmable
//               almost-full / almost-empty thresholds, live occupancy count
//               and an optional first-word-fall-through read mode.
// Ports       : clk         - clock, rising edge
//               rst_n       - asynchronous active-low reset
//               data_in     - write data
//               wr_en       - write request
//               rd_en       - read request (pop in FWFT mode)
//               data_out    - read data (registered, or head word in FWFT)
//               wr_ack      - previous-cycle write accepted
//               overflow    - previous-cycle write rejected (full)
//               underflow   - previous-cycle read rejected (empty)
//               full        - count == FIFO_DEPTH
//               empty       - count == 0
//               almostfull  - count == AF_THRESH
//               almostempty - count == AE_THRESH
//               count       - current occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_gen
    import fifo_gen_pkg::*;
#(
    parameter int FIFO_WIDTH = c_DEFAULT_WIDTH,
    parameter int FIFO_DEPTH = c_DEFAULT_DEPTH,
    parameter int AF_THRESH  = FIFO_DEPTH - 1,
    parameter int AE_THRESH  = 1,
    parameter int FWFT       = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [FIFO_WIDTH-1:0]            data_in,
    input  logic                             wr_en,
    input  logic                             rd_en,
    output logic [FIFO_WIDTH-1:0]            data_out,
    output logic                             wr_ack,
    output logic                             overflow,
    output logic                             underflow,
    output logic                             full,
    output logic                             empty,
    output logic                             almostfull,
    output logic                             almostempty,
    output logic [cnt_w(FIFO_DEPTH)-1:0]     count
);

    localparam int                c_CW       = cnt_w(FIFO_DEPTH);
    localparam int                c_PW       = ptr_w(FIFO_DEPTH);
    localparam logic [c_CW-1:0]   c_CNT_FULL = c_CW'(FIFO_DEPTH);
    localparam logic [c_CW-1:0]   c_CNT_AF   = c_CW'(AF_THRESH);
    localparam logic [c_CW-1:0]   c_CNT_AE   = c_CW'(AE_THRESH);
    localparam logic [c_CW-1:0]   c_CNT_ONE  = c_CW'(1);
    localparam logic [c_PW-1:0]   c_PTR_LAST = c_PW'(FIFO_DEPTH - 1);
    localparam logic [c_PW-1:0]   c_PTR_ONE  = c_PW'(1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (FIFO_WIDTH < 1 || FIFO_DEPTH < 2) begin : g_bad_geometry
        $fatal(1, "sync_fifo_gen: FIFO_WIDTH must be >= 1 and FIFO_DEPTH >= 2");
    end

    if (!((AE_THRESH >= 0) && (AE_THRESH < AF_THRESH) &&
          (AF_THRESH <= FIFO_DEPTH))) begin : g_bad_thresh
        $fatal(1, "sync_fifo_gen: need 0 <= AE_THRESH < AF_THRESH <= FIFO_DEPTH");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_PW-1:0]       r_wr_ptr;
    logic [c_PW-1:0]       r_rd_ptr;
    logic [c_CW-1:0]       r_count;
    logic                  r_wr_ack;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [FIFO_WIDTH-1:0] w_mem_rd;

    // Flags are a pure decode of the registered count, so no request input
    // ever reaches an output combinationally.
    assign w_full   = (r_count == c_CNT_FULL);
    assign w_empty  = (r_count == '0);

    // Acceptance is judged on pre-edge occupancy: a full FIFO rejects a
    // write even if a read is popping in the same cycle, and vice versa.
    assign w_wr_acc = wr_en & ~w_full;
    assign w_rd_acc = rd_en & ~w_empty;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    fifo_gen_mem #(
        .FIFO_WIDTH (FIFO_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk        (clk),
        .i_wr_en    (w_wr_acc),
        .i_wr_addr  (r_wr_ptr),
        .i_wr_data  (data_in),
        .i_rd_addr  (r_rd_ptr),
        .o_rd_data  (w_mem_rd)
    );

    // ------------------------------------------------------------------
    // Pointers, occupancy and handshake status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ack    <= w_wr_acc;
            r_overflow  <= wr_en & w_full;
            r_underflow <= rd_en & w_empty;

            // Explicit wrap compare keeps non-power-of-two depths correct.
            if (w_wr_acc) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : (r_wr_ptr + c_PTR_ONE);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : (r_rd_ptr + c_PTR_ONE);
            end

            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------
    if (FWFT != 0) begin : g_fwft
        // Head word is presented as soon as it is stored; forced to zero
        // while empty so stale storage never leaks out.
        assign data_out = w_empty ? '0 : w_mem_rd;
    end else begin : g_std
        logic [FIFO_WIDTH-1:0] r_data_out;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_data_out <= '0;
            end else if (w_rd_acc) begin
                r_data_out <= w_mem_rd;
            end
        end

        assign data_out = r_data_out;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wr_ack      = r_wr_ack;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almostfull  = (r_count == c_CNT_AF);
    assign almostempty = (r_count == c_CNT_AE);
    assign count       = r_count;

endmodule : sync_fifo_gen
`default_nettype wire

// File: tb/tb_sync_fifo_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_gen
// Description : Self-checking bench for sync_fifo_gen. Three instances share
//               one stimulus stream:
//                 u0 : W=16 D=8 AF=7 AE=1 FWFT=0
//                 u1 : W=16 D=6 AF=5 AE=1 FWFT=0
//                 u2 : W=16 D=5 AF=3 AE=2 FWFT=1
//               A queue-based reference model predicts every output each
//               cycle; literal expectations pin the directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_gen;
    import fifo_gen_pkg::*;

    localparam int c_W = c_DEFAULT_WIDTH;
    localparam int c_N = 3;

    function automatic int dep_of(input int i);
        case (i)
            0:       return c_DEFAULT_DEPTH;
            1:       return 6;
            default: return 5;
        endcase
    endfunction

    function automatic int af_of(input int i);
        case (i)
            0:       return c_DEFAULT_DEPTH - 1;
            1:       return 5;
            default: return 3;
        endcase
    endfunction

    function automatic int ae_of(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    function automatic int fwft_of(input int i);
        return (i == 2) ? 1 : 0;
    endfunction

    logic           clk     = 1'b0;
    logic           rst_n   = 1'b1;
    logic           wr_en   = 1'b0;
    logic           rd_en   = 1'b0;
    logic [c_W-1:0] data_in = '0;

    logic [c_N-1:0][c_W-1:0] dout;
    logic [c_N-1:0][7:0]     cnt;
    logic [c_N-1:0]          ack, ovf, unf, fl, em, af, ae;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < c_N; g++) begin : g_dut
        localparam int D = dep_of(g);
        logic [cnt_w(D)-1:0] w_cnt;

        sync_fifo_gen #(
            .FIFO_WIDTH (c_W),
            .FIFO_DEPTH (D),
            .AF_THRESH  (af_of(g)),
            .AE_THRESH  (ae_of(g)),
            .FWFT       (fwft_of(g))
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .data_in     (data_in),
            .wr_en       (wr_en),
            .rd_en       (rd_en),
            .data_out    (dout[g]),
            .wr_ack      (ack[g]),
            .overflow    (ovf[g]),
            .underflow   (unf[g]),
            .full        (fl[g]),
            .empty       (em[g]),
            .almostfull  (af[g]),
            .almostempty (ae[g]),
            .count       (w_cnt)
        );

        assign cnt[g] = 8'(w_cnt);
    end

    // ------------------------------------------------------------------
    // Reference model: one queue per instance plus the registered status
    // ------------------------------------------------------------------
    logic [c_W-1:0]          mq [c_N][$];
    logic [c_N-1:0][c_W-1:0] m_dout = '0;
    logic [c_N-1:0]          m_ack  = '0;
    logic [c_N-1:0]          m_ovf  = '0;
    logic [c_N-1:0]          m_unf  = '0;

    always @(posedge clk or negedge rst_n) begin : p_model
        int sz;
        bit wa, ra;
        if (!rst_n) begin
            for (int i = 0; i < c_N; i++) begin
                mq[i].delete();
            end
            m_dout = '0;
            m_ack  = '0;
            m_ovf  = '0;
            m_unf  = '0;
        end else begin
            for (int i = 0; i < c_N; i++) begin
                sz       = mq[i].size();
                wa       = wr_en && (sz < dep_of(i));
                ra       = rd_en && (sz > 0);
                m_ack[i] = wa;
                m_ovf[i] = wr_en && (sz == dep_of(i));
                m_unf[i] = rd_en && (sz == 0);
                if (ra) begin
                    if (fwft_of(i) == 0) m_dout[i] = mq[i][0];
                    void'(mq[i].pop_front());
                end
                if (wa) mq[i].push_back(data_in);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin : p_cmp
        int sz;
        logic [c_W-1:0] ed;
        if (chk_en) begin
            for (int i = 0; i < c_N; i++) begin
                sz = mq[i].size();
                if (fwft_of(i) != 0) ed = (sz > 0) ? mq[i][0] : '0;
                else                 ed = m_dout[i];
                check($sformatf("u%0d.count", i),       32'(cnt[i]), 32'(sz));
                check($sformatf("u%0d.full", i),        32'(fl[i]),  32'(sz == dep_of(i)));
                check($sformatf("u%0d.empty", i),       32'(em[i]),  32'(sz == 0));
                check($sformatf("u%0d.almostfull", i),  32'(af[i]),  32'(sz == af_of(i)));
                check($sformatf("u%0d.almostempty", i), 32'(ae[i]),  32'(sz == ae_of(i)));
                check($sformatf("u%0d.wr_ack", i),      32'(ack[i]), 32'(m_ack[i]));
                check($sformatf("u%0d.overflow", i),    32'(ovf[i]), 32'(m_ovf[i]));
                check($sformatf("u%0d.underflow", i),   32'(unf[i]), 32'(m_unf[i]));
                check($sformatf("u%0d.data_out", i),    32'(dout[i]), 32'(ed));
            end
        end
    end

    // Apply inputs at a falling edge and return at the next falling edge.
    task automatic drive(input logic w, input logic r, input logic [c_W-1:0] d);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(negedge clk);
    endtask

    initial begin : p_stim
        int pw, pr;

        // Reset
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        check("rst.count", 32'(cnt[0]), 32'd0);
        check("rst.empty", 32'(em[0]), 32'd1);
        check("rst.full",  32'(fl[0]), 32'd0);
        check("rst.ae_u2", 32'(ae[2]), 32'd0);

        // 1. Fill u0 with 1..8, then one write too many
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 1'b0, c_W'(k));
            check("t1.wr_ack", 32'(ack[0]), 32'd1);
            if (k == 7) begin
                check("t1.af_at7",  32'(af[0]),  32'd1);
                check("t1.count7",  32'(cnt[0]), 32'd7);
            end
        end
        check("t1.full",   32'(fl[0]),  32'd1);
        check("t1.count8", 32'(cnt[0]), 32'd8);
        drive(1'b1, 1'b0, 16'h0009);
        check("t1.overflow", 32'(ovf[0]), 32'd1);
        check("t1.no_ack",   32'(ack[0]), 32'd0);
        check("t1.count_hold", 32'(cnt[0]), 32'd8);

        // 2. Drain u0, then one read too many
        for (int k = 1; k <= 8; k++) begin
            drive(1'b0, 1'b1, '0);
            check("t2.data", 32'(dout[0]), 32'(k));
            if (k == 7) check("t2.ae_at1", 32'(ae[0]), 32'd1);
        end
        check("t2.empty", 32'(em[0]), 32'd1);
        drive(1'b0, 1'b1, '0);
        check("t2.underflow", 32'(unf[0]), 32'd1);
        check("t2.data_hold", 32'(dout[0]), 32'h8);

        // 3. Simultaneous access at mid, full and empty
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, c_W'(16'h10 + k));
        drive(1'b1, 1'b1, 16'h0014);
        check("t3.mid_count", 32'(cnt[0]), 32'd4);
        check("t3.mid_ack",   32'(ack[0]), 32'd1);
        check("t3.mid_ovf",   32'(ovf[0]), 32'd0);
        check("t3.mid_unf",   32'(unf[0]), 32'd0);
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, c_W'(16'h15 + k));
        drive(1'b1, 1'b1, 16'h00AA);
        check("t3.full_head", 32'(dout[0]), 32'h11);
        check("t3.full_ovf",  32'(ovf[0]),  32'd1);
        check("t3.full_cnt",  32'(cnt[0]),  32'd7);
        repeat (7) drive(1'b0, 1'b1, '0);
        check("t3.drained", 32'(em[0]), 32'd1);
        drive(1'b1, 1'b1, 16'h0099);
        check("t3.empty_unf", 32'(unf[0]), 32'd1);
        check("t3.empty_ack", 32'(ack[0]), 32'd1);
        check("t3.empty_cnt", 32'(cnt[0]), 32'd1);
        drive(1'b0, 1'b1, '0);

        // 4. Interleaved write/read across pointer wrap, then random traffic
        for (int n = 0; n < 20; n++) begin
            drive(1'b1, 1'b0, c_W'(16'h100 + n));
            drive(1'b0, 1'b1, '0);
            check("t4.order", 32'(dout[0]), 32'(16'h100 + n));
        end
        for (int ph = 0; ph < 3; ph++) begin
            pw = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
            pr = (ph == 0) ? 30 : (ph == 1) ? 75 : 50;
            for (int c = 0; c < 150; c++) begin
                drive(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr),
                      c_W'($urandom));
            end
        end

        // 5. FWFT head visibility on u2
        repeat (10) drive(1'b0, 1'b1, '0);
        drive(1'b1, 1'b0, 16'hBEEF);
        check("t5.fwft_head", 32'(dout[2]), 32'hBEEF);
        drive(1'b0, 1'b0, '0);
        check("t5.fwft_hold", 32'(dout[2]), 32'hBEEF);
        drive(1'b0, 1'b1, '0);
        check("t5.fwft_empty", 32'(em[2]),   32'd1);
        check("t5.fwft_zero",  32'(dout[2]), 32'd0);

        // 6. Asynchronous reset mid-operation
        for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, c_W'(16'h50 + k));
        check("t6.count5", 32'(cnt[0]), 32'd5);
        wr_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("t6.rst_count", 32'(cnt[0]), 32'd0);
        check("t6.rst_empty", 32'(em[0]),  32'd1);
        check("t6.rst_ack",   32'(ack[0]), 32'd0);
        #4 rst_n = 1'b1;
        @(negedge clk);
        drive(1'b1, 1'b0, 16'h0077);
        check("t6.fwft_new", 32'(dout[2]), 32'h77);
        drive(1'b0, 1'b1, '0);
        check("t6.new_word", 32'(dout[0]), 32'h77);
        check("t6.empty",    32'(em[0]),   32'd1);

        repeat (3) drive(1'b0, 1'b0, '0);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sync_fifo_gen
`default_nettype wire
